// File: rtl/order_matcher_pkg.sv
// Shared types and defaults for the single-level order matcher.
// The state enum, side encoding and default widths live here so the bench and RTL agree.
package order_matcher_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MATCH,
        TRADE,
        REST
    } state_t;

    localparam logic SIDE_BUY  = 1'b0;
    localparam logic SIDE_SELL = 1'b1;

    localparam int DEF_PRICE_W = 8;
    localparam int DEF_QTY_W   = 8;
    localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/order_matcher_price_sub.sv
// Ripple subtractor: diff = a - b as a + ~b + 1; the final carry-out is the a >= b flag.
module price_sub #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         ge
);

    logic [W:0] carry;

    always_comb begin
        carry    = '0;
        diff     = '0;
        carry[0] = 1'b1;
        for (int i = 0; i < W; i++) begin
            diff[i]      = a[i] ^ ~b[i] ^ carry[i];
            carry[i + 1] = (a[i] & ~b[i]) | (carry[i] & (a[i] ^ ~b[i]));
        end
        ge = carry[W];
    end

endmodule

// File: rtl/order_matcher.sv
// One-level limit order book: an incoming order matches the best opposite resting order,
// emits at most one trade record, then rests its remainder or drops it.
module order_matcher
    import order_matcher_pkg::*;
#(
    parameter int PRICE_W = DEF_PRICE_W,
    parameter int QTY_W   = DEF_QTY_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_side,
    input  logic [PRICE_W-1:0] in_price,
    input  logic [QTY_W-1:0]   in_qty,
    output logic               trade_valid,
    input  logic               trade_ready,
    output logic [PRICE_W-1:0] trade_price,
    output logic [QTY_W-1:0]   trade_qty,
    output logic               trade_aggr_side,
    output logic               bid_valid,
    output logic               ask_valid,
    output logic [PRICE_W-1:0] bid_price,
    output logic [PRICE_W-1:0] ask_price,
    output logic [QTY_W-1:0]   bid_qty,
    output logic [QTY_W-1:0]   ask_qty,
    output logic [PRICE_W-1:0] spread,
    output logic               spread_valid,
    output logic               drop_pulse,
    output logic [CNT_W-1:0]   trade_count,
    output logic [CNT_W-1:0]   drop_count
);

    state_t             state, state_next;
    logic               w_side;
    logic [PRICE_W-1:0] w_price;
    logic [QTY_W-1:0]   w_qty;

    logic [PRICE_W-1:0] diff_aw, diff_wb, diff_spread;
    logic               ge_aw, ge_wb, ge_spread;

    price_sub #(.W(PRICE_W)) u_sub_ask (.a(ask_price), .b(w_price), .diff(diff_aw), .ge(ge_aw));
    price_sub #(.W(PRICE_W)) u_sub_bid (.a(w_price), .b(bid_price), .diff(diff_wb), .ge(ge_wb));
    price_sub #(.W(PRICE_W)) u_sub_spread (.a(ask_price), .b(bid_price), .diff(diff_spread), .ge(ge_spread));

    // Strict orderings come from the >= flag plus a nonzero difference.
    logic ask_gt_w, w_gt_bid, cross_now, improve_now;
    logic [PRICE_W-1:0] opp_price;
    logic [QTY_W-1:0]   opp_qty, fill_qty, w_rem, opp_rem;

    assign ask_gt_w    = ge_aw & (|diff_aw);
    assign w_gt_bid    = ge_wb & (|diff_wb);
    assign cross_now   = (w_side == SIDE_BUY) ? (ask_valid & ~ask_gt_w) : (bid_valid & ~w_gt_bid);
    assign improve_now = (w_side == SIDE_BUY) ? (~bid_valid | w_gt_bid) : (~ask_valid | ask_gt_w);
    assign opp_price   = (w_side == SIDE_BUY) ? ask_price : bid_price;
    assign opp_qty     = (w_side == SIDE_BUY) ? ask_qty : bid_qty;
    assign fill_qty    = (w_qty < opp_qty) ? w_qty : opp_qty;
    assign w_rem       = w_qty - trade_qty;
    assign opp_rem     = opp_qty - trade_qty;
    assign in_ready    = (state == IDLE) && !rst;

    logic do_accept, do_trade, do_handshake, do_rest, do_drop;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = state;
        do_accept    = 1'b0;
        do_trade     = 1'b0;
        do_handshake = 1'b0;
        do_rest      = 1'b0;
        do_drop      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    do_accept  = 1'b1;
                    state_next = MATCH;
                end
            end
            MATCH: begin
                if (w_qty == '0) begin
                    do_drop    = 1'b1;
                    state_next = IDLE;
                end else if (cross_now) begin
                    do_trade   = 1'b1;
                    state_next = TRADE;
                end else begin
                    state_next = REST;
                end
            end
            TRADE: begin
                if (trade_ready) begin
                    do_handshake = 1'b1;
                    state_next   = (w_rem == '0) ? IDLE : REST;
                end
            end
            REST: begin
                do_rest    = improve_now;
                do_drop    = ~improve_now;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: working order, trade record, book, spread and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_side <= SIDE_BUY;  w_price <= '0;  w_qty <= '0;
            trade_valid <= 1'b0; trade_price <= '0; trade_qty <= '0; trade_aggr_side <= 1'b0;
            bid_valid <= 1'b0;   bid_price <= '0; bid_qty <= '0;
            ask_valid <= 1'b0;   ask_price <= '0; ask_qty <= '0;
            spread <= '0;        spread_valid <= 1'b0;
            drop_pulse <= 1'b0;  trade_count <= '0; drop_count <= '0;
        end else begin
            drop_pulse   <= do_drop;
            spread_valid <= bid_valid && ask_valid;
            spread       <= (bid_valid && ask_valid && ge_spread) ? diff_spread : '0;
            if (do_accept) begin
                w_side  <= in_side;
                w_price <= in_price;
                w_qty   <= in_qty;
            end
            if (do_trade) begin
                trade_valid     <= 1'b1;
                trade_price     <= opp_price;
                trade_qty       <= fill_qty;
                trade_aggr_side <= w_side;
            end
            if (do_handshake) begin
                trade_valid <= 1'b0;
                w_qty       <= w_rem;
                if (w_side == SIDE_BUY) begin
                    ask_qty <= opp_rem;
                    if (opp_rem == '0) ask_valid <= 1'b0;
                end else begin
                    bid_qty <= opp_rem;
                    if (opp_rem == '0) bid_valid <= 1'b0;
                end
                if (trade_count != '1) trade_count <= trade_count + CNT_W'(1);
            end
            if (do_rest) begin
                if (w_side == SIDE_BUY) begin
                    bid_valid <= 1'b1; bid_price <= w_price; bid_qty <= w_qty;
                end else begin
                    ask_valid <= 1'b1; ask_price <= w_price; ask_qty <= w_qty;
                end
            end
            if (do_drop && drop_count != '1) drop_count <= drop_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_order_matcher.sv
// Scoreboard bench for order_matcher: a behavioural book model predicts trades, drops and
// book contents; expected trades are queued at issue and popped on each trade handshake.
module tb_order_matcher;

    localparam logic BUY  = 1'b0;
    localparam logic SELL = 1'b1;
    localparam int   CNT_MAX = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_side;
    logic [7:0] in_price, in_qty;
    logic       trade_valid, tr_ready, trade_aggr_side;
    logic [7:0] trade_price, trade_qty;
    logic       bid_valid, ask_valid, spread_valid, drop_pulse;
    logic [7:0] bid_price, ask_price, bid_qty, ask_qty, spread;
    logic [3:0] trade_count, drop_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] price;
        logic [7:0] qty;
        logic       side;
    } trade_t;
    trade_t exp_q[$];

    logic       m_bid_v, m_ask_v;
    logic [7:0] m_bid_p, m_bid_q, m_ask_p, m_ask_q;
    int         m_trades, m_drops;

    order_matcher #(.PRICE_W(8), .QTY_W(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_side(in_side),
        .in_price(in_price), .in_qty(in_qty),
        .trade_valid(trade_valid), .trade_ready(tr_ready),
        .trade_price(trade_price), .trade_qty(trade_qty), .trade_aggr_side(trade_aggr_side),
        .bid_valid(bid_valid), .ask_valid(ask_valid),
        .bid_price(bid_price), .ask_price(ask_price),
        .bid_qty(bid_qty), .ask_qty(ask_qty),
        .spread(spread), .spread_valid(spread_valid), .drop_pulse(drop_pulse),
        .trade_count(trade_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Scoreboard side: every completed trade handshake must match the oldest prediction.
    always @(negedge clk) begin
        if (!rst && trade_valid && tr_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("trade_unexpected", 1, 0);
            end else begin
                trade_t t;
                t = exp_q.pop_front();
                checkOutput("trade_price", trade_price, t.price);
                checkOutput("trade_qty", trade_qty, t.qty);
                checkOutput("trade_side", trade_aggr_side, t.side);
            end
        end
    end

    task automatic modelReset();
        m_bid_v = 0; m_ask_v = 0;
        m_bid_p = 0; m_bid_q = 0; m_ask_p = 0; m_ask_q = 0;
        m_trades = 0; m_drops = 0;
    endtask

    task automatic modelOrder(input logic side, input logic [7:0] price, input logic [7:0] qty,
                              output logic got_trade, output logic got_drop);
        trade_t     t;
        logic [7:0] q;
        q = qty;
        got_trade = 0;
        got_drop  = 0;
        if (q == 0) begin
            got_drop = 1;
        end else begin
            if (side == BUY && m_ask_v && price >= m_ask_p) begin
                t.price = m_ask_p; t.qty = (q < m_ask_q) ? q : m_ask_q; t.side = BUY;
                m_ask_q = m_ask_q - t.qty; q = q - t.qty;
                if (m_ask_q == 0) m_ask_v = 0;
                got_trade = 1;
            end else if (side == SELL && m_bid_v && price <= m_bid_p) begin
                t.price = m_bid_p; t.qty = (q < m_bid_q) ? q : m_bid_q; t.side = SELL;
                m_bid_q = m_bid_q - t.qty; q = q - t.qty;
                if (m_bid_q == 0) m_bid_v = 0;
                got_trade = 1;
            end
            if (got_trade) begin
                exp_q.push_back(t);
                m_trades++;
            end
            if (q != 0) begin
                if (side == BUY && (!m_bid_v || price > m_bid_p)) begin
                    m_bid_v = 1; m_bid_p = price; m_bid_q = q;
                end else if (side == SELL && (!m_ask_v || price < m_ask_p)) begin
                    m_ask_v = 1; m_ask_p = price; m_ask_q = q;
                end else begin
                    got_drop = 1;
                end
            end
        end
        if (got_drop) m_drops++;
    endtask

    task automatic sendOrder(input logic side, input logic [7:0] price, input logic [7:0] qty);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkOutput("accept_timeout", 0, 1);
        in_valid = 1; in_side = side; in_price = price; in_qty = qty;
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic applyStimulus(input logic side, input logic [7:0] price, input logic [7:0] qty);
        logic exp_trade, exp_drop;
        int   n = 0;
        modelOrder(side, price, qty, exp_trade, exp_drop);
        sendOrder(side, price, qty);
        @(negedge clk);
        checkOutput("match_in_ready", in_ready, 0);
        checkOutput("match_trade_valid", trade_valid, 0);
        @(negedge clk);
        checkOutput("trade_valid_latency", trade_valid, exp_trade);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkOutput("idle_timeout", 0, 1);
        else           checkOutput("drop_pulse", drop_pulse, exp_drop);
    endtask

    task automatic checkBook();
        int exp_tc, exp_dc;
        @(negedge clk);
        exp_tc = (m_trades > CNT_MAX) ? CNT_MAX : m_trades;
        exp_dc = (m_drops > CNT_MAX) ? CNT_MAX : m_drops;
        checkOutput("bid_valid", bid_valid, m_bid_v);
        checkOutput("ask_valid", ask_valid, m_ask_v);
        if (m_bid_v) begin
            checkOutput("bid_price", bid_price, m_bid_p);
            checkOutput("bid_qty", bid_qty, m_bid_q);
        end
        if (m_ask_v) begin
            checkOutput("ask_price", ask_price, m_ask_p);
            checkOutput("ask_qty", ask_qty, m_ask_q);
        end
        checkOutput("spread_valid", spread_valid, m_bid_v && m_ask_v);
        checkOutput("spread", spread, (m_bid_v && m_ask_v) ? 8'(m_ask_p - m_bid_p) : 8'd0);
        checkOutput("trade_count", trade_count, exp_tc);
        checkOutput("drop_count", drop_count, exp_dc);
    endtask

    task automatic holdCheck();
        int n = 0;
        @(negedge clk);
        while (!trade_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!trade_valid) begin
            checkOutput("hold_timeout", 0, 1);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checkOutput("hold_valid", trade_valid, 1);
                checkOutput("hold_price", trade_price, 120);
                checkOutput("hold_qty", trade_qty, 5);
                checkOutput("hold_side", trade_aggr_side, BUY);
                checkOutput("hold_in_ready", in_ready, 0);
                @(negedge clk);
            end
        end
        tr_ready = 1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst = 1; in_valid = 0; in_side = 0; in_price = 0; in_qty = 0; tr_ready = 1;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_trade_valid", trade_valid, 0);
        checkOutput("rst_bid_valid", bid_valid, 0);
        checkOutput("rst_ask_valid", ask_valid, 0);
        checkOutput("rst_spread_valid", spread_valid, 0);
        checkOutput("rst_drop_pulse", drop_pulse, 0);
        checkOutput("rst_counts", {trade_count, drop_count}, 0);
        rst = 0;
        @(negedge clk);
        checkOutput("ready_after_rst", in_ready, 1);

        applyStimulus(BUY, 100, 10);
        checkBook();
        applyStimulus(SELL, 95, 4);
        checkBook();
        applyStimulus(BUY, 90, 2);
        checkBook();
        applyStimulus(SELL, 120, 5);
        checkBook();

        tr_ready = 0;
        fork
            applyStimulus(BUY, 130, 8);
            holdCheck();
        join
        checkBook();

        applyStimulus(SELL, 50, 0);
        checkBook();
        applyStimulus(SELL, 140, 2);
        applyStimulus(SELL, 150, 1);
        applyStimulus(SELL, 135, 1);
        checkBook();

        // Reset while a trade record is waiting for its handshake.
        tr_ready = 0;
        sendOrder(BUY, 135, 1);
        n = 0;
        @(negedge clk);
        while (!trade_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("pre_rst_trade_valid", trade_valid, 1);
        rst = 1;
        @(negedge clk);
        checkOutput("midrst_trade_valid", trade_valid, 0);
        checkOutput("midrst_bid_valid", bid_valid, 0);
        checkOutput("midrst_ask_valid", ask_valid, 0);
        checkOutput("midrst_counts", {trade_count, drop_count}, 0);
        checkOutput("midrst_in_ready", in_ready, 0);
        rst = 0;
        tr_ready = 1;
        modelReset();
        @(negedge clk);
        checkOutput("ready_after_midrst", in_ready, 1);

        for (int i = 0; i < CNT_MAX; i++) begin
            applyStimulus(SELL, 200, 1);
            applyStimulus(BUY, 200, 1);
        end
        checkBook();
        applyStimulus(SELL, 200, 1);
        applyStimulus(BUY, 200, 1);
        checkBook();
        checkOutput("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
